// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Control FSM for a classic multicycle MIPS-style datapath. It sequences
// fetch, decode, memory, R-type, beq, addi and j instructions, drives the
// datapath control lines as Moore decodes of the current state, flags
// unsupported opcodes, and counts retired instructions.
//
// Ports
//   clk          in   sole clock, rising edge
//   reset        in   asynchronous, active-high reset
//   opcode[5:0]  in   instruction[31:26] from the instruction register
//   mem_ready    in   memory completion handshake (used in FETCH, MEM_RD, MEM_WR)
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
//   RegDst, RegWrite, ALUSrcA                       out  1-bit datapath controls
//   ALUSrcB[1:0]  out  00 B, 01 const 4, 10 sext imm, 11 sext imm << 2
//   PCSource[1:0] out  00 ALU result, 01 ALUOut, 10 jump target
//   ALUOp[1:0]    out  00 add, 01 sub, 10 funct-decoded
//   state[3:0]    out  current FSM state (debug)
//   illegal_op    out  high during the DECODE cycle of an unsupported opcode
//   instr_count   out  retired-instruction counter, CNT_W bits, wraps
// -----------------------------------------------------------------------------
module multicycle_control #(
    parameter bit ENABLE_ADDI = 1'b1,
    parameter bit ENABLE_J    = 1'b1,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       PCSource,
    output logic [1:0]       ALUOp,
    output logic [3:0]       state,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADDR  = 4'd2;
    localparam logic [3:0] S_MEM_RD    = 4'd3;
    localparam logic [3:0] S_MEM_WB    = 4'd4;
    localparam logic [3:0] S_MEM_WR    = 4'd5;
    localparam logic [3:0] S_R_EXEC    = 4'd6;
    localparam logic [3:0] S_R_WB      = 4'd7;
    localparam logic [3:0] S_BEQ       = 4'd8;
    localparam logic [3:0] S_ADDI_EXEC = 4'd9;
    localparam logic [3:0] S_ADDI_WB   = 4'd10;
    localparam logic [3:0] S_JUMP      = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal_d;
    logic             retire;

    // Raw Moore decodes; the memory/register write strobes are gated by
    // reset further down.
    logic pcwrite_raw, pcwritecond_raw, memread_raw, memwrite_raw;
    logic irwrite_raw, regwrite_raw;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = S_FETCH;
        illegal_d = 1'b0;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE:     state_d = S_R_EXEC;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_ADDI: begin
                        if (ENABLE_ADDI) state_d = S_ADDI_EXEC;
                        else             illegal_d = 1'b1;
                    end
                    OP_J: begin
                        if (ENABLE_J) state_d = S_JUMP;
                        else          illegal_d = 1'b1;
                    end
                    default:      illegal_d = 1'b1;
                endcase
            end
            // The IR still holds the lw/sw opcode, so it selects the access.
            S_MEM_ADDR:  state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:    state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WR:    state_d = mem_ready ? S_FETCH : S_MEM_WR;
            S_R_EXEC:    state_d = S_R_WB;
            S_R_WB:      state_d = S_FETCH;
            S_BEQ:       state_d = S_FETCH;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_ADDI_WB:   state_d = S_FETCH;
            S_JUMP:      state_d = S_FETCH;
            default:     state_d = S_FETCH;   // unreachable codes recover
        endcase
    end

    // An instruction retires only when one of its final states hands back
    // to FETCH; the illegal-opcode return from DECODE is not counted.
    always_comb begin
        retire = 1'b0;
        if (state_d == S_FETCH) begin
            case (state_q)
                S_MEM_WB, S_MEM_WR, S_R_WB, S_BEQ, S_ADDI_WB, S_JUMP: retire = 1'b1;
                default: retire = 1'b0;
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (retire) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        pcwrite_raw     = 1'b0;
        pcwritecond_raw = 1'b0;
        memread_raw     = 1'b0;
        memwrite_raw    = 1'b0;
        irwrite_raw     = 1'b0;
        regwrite_raw    = 1'b0;
        IorD            = 1'b0;
        MemtoReg        = 1'b0;
        RegDst          = 1'b0;
        ALUSrcA         = 1'b0;
        ALUSrcB         = 2'b00;
        PCSource        = 2'b00;
        ALUOp           = 2'b00;
        case (state_q)
            S_FETCH: begin
                memread_raw = 1'b1;
                ALUSrcB     = 2'b01;
                // IR load and PC+4 happen only in the completing cycle.
                irwrite_raw = mem_ready;
                pcwrite_raw = mem_ready;
            end
            S_DECODE: ALUSrcB = 2'b11;
            S_MEM_ADDR, S_ADDI_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEM_RD: begin
                memread_raw = 1'b1;
                IorD        = 1'b1;
            end
            S_MEM_WB: begin
                regwrite_raw = 1'b1;
                MemtoReg     = 1'b1;
            end
            S_MEM_WR: begin
                memwrite_raw = 1'b1;
                IorD         = 1'b1;
            end
            S_R_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_R_WB: begin
                regwrite_raw = 1'b1;
                RegDst       = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA         = 1'b1;
                ALUOp           = 2'b01;
                pcwritecond_raw = 1'b1;
                PCSource        = 2'b01;
            end
            S_ADDI_WB: regwrite_raw = 1'b1;
            S_JUMP: begin
                pcwrite_raw = 1'b1;
                PCSource    = 2'b10;
            end
            default: ;
        endcase
    end

    // Reset forces state to FETCH asynchronously, but FETCH itself asserts
    // MemRead, so the architectural strobes are also masked directly.
    assign PCWrite     = pcwrite_raw     & ~reset;
    assign PCWriteCond = pcwritecond_raw & ~reset;
    assign MemRead     = memread_raw     & ~reset;
    assign MemWrite    = memwrite_raw    & ~reset;
    assign IRWrite     = irwrite_raw     & ~reset;
    assign RegWrite    = regwrite_raw    & ~reset;
    assign illegal_op  = (state_q == S_DECODE) & illegal_d & ~reset;

    assign state       = state_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
//
// Two instances: dut 0 with default parameters, dut 1 with addi/j disabled
// and a 4-bit counter. The stimulus process walks each instruction cycle by
// cycle and pushes the hand-derived expected state/controls for that cycle;
// a monitor on the falling edge pops and compares.
// Control word layout: {PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
// MemtoReg, IRWrite, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp}.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst_s;
    logic [1:0]       mr_s;
    logic [1:0][5:0]  op_s;

    logic [1:0]       pcw, pcwc, iord, mrd, mwr, m2r, irw, rdst, rw, asa, ill;
    logic [1:0][1:0]  asb, psrc, aop;
    logic [1:0][3:0]  st;
    logic [31:0]      cnt0;
    logic [3:0]       cnt1;
    logic [1:0][15:0] ctrl_w;

    multicycle_control dut0 (
        .clk(clk), .reset(rst_s[0]), .opcode(op_s[0]), .mem_ready(mr_s[0]),
        .PCWrite(pcw[0]), .PCWriteCond(pcwc[0]), .IorD(iord[0]), .MemRead(mrd[0]),
        .MemWrite(mwr[0]), .MemtoReg(m2r[0]), .IRWrite(irw[0]), .RegDst(rdst[0]),
        .RegWrite(rw[0]), .ALUSrcA(asa[0]), .ALUSrcB(asb[0]), .PCSource(psrc[0]),
        .ALUOp(aop[0]), .state(st[0]), .illegal_op(ill[0]), .instr_count(cnt0)
    );

    multicycle_control #(.ENABLE_ADDI(1'b0), .ENABLE_J(1'b0), .CNT_W(4)) dut1 (
        .clk(clk), .reset(rst_s[1]), .opcode(op_s[1]), .mem_ready(mr_s[1]),
        .PCWrite(pcw[1]), .PCWriteCond(pcwc[1]), .IorD(iord[1]), .MemRead(mrd[1]),
        .MemWrite(mwr[1]), .MemtoReg(m2r[1]), .IRWrite(irw[1]), .RegDst(rdst[1]),
        .RegWrite(rw[1]), .ALUSrcA(asa[1]), .ALUSrcB(asb[1]), .PCSource(psrc[1]),
        .ALUOp(aop[1]), .state(st[1]), .illegal_op(ill[1]), .instr_count(cnt1)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ctrl
            assign ctrl_w[gi] = {pcw[gi], pcwc[gi], iord[gi], mrd[gi], mwr[gi], m2r[gi],
                                 irw[gi], rdst[gi], rw[gi], asa[gi], asb[gi], psrc[gi], aop[gi]};
        end
    endgenerate

    typedef struct packed {
        logic [3:0]  st;
        logic [15:0] ctrl;
        logic        ill;
        logic [31:0] cnt;
        logic [63:0] tag;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    int          nvec  = 0;
    int          nfail = 0;
    int          cnt_m[2];
    logic [63:0] cur_tag;
    logic        ign;

    // Expected controls per state, written straight from the state table.
    function automatic logic [15:0] ctrl_of(input logic [3:0] s, input logic mr, input logic rst);
        logic p_w, p_wc, i_d, m_rd, m_wr, m_tr, ir_w, r_d, r_w, a_a;
        logic [1:0] a_b, p_s, a_o;
        {p_w, p_wc, i_d, m_rd, m_wr, m_tr, ir_w, r_d, r_w, a_a} = '0;
        a_b = 2'b00; p_s = 2'b00; a_o = 2'b00;
        case (s)
            4'd0:  begin m_rd = 1; a_b = 2'b01; ir_w = mr; p_w = mr; end
            4'd1:  a_b = 2'b11;
            4'd2:  begin a_a = 1; a_b = 2'b10; end
            4'd3:  begin m_rd = 1; i_d = 1; end
            4'd4:  begin r_w = 1; m_tr = 1; end
            4'd5:  begin m_wr = 1; i_d = 1; end
            4'd6:  begin a_a = 1; a_o = 2'b10; end
            4'd7:  begin r_w = 1; r_d = 1; end
            4'd8:  begin a_a = 1; a_o = 2'b01; p_wc = 1; p_s = 2'b01; end
            4'd9:  begin a_a = 1; a_b = 2'b10; end
            4'd10: r_w = 1;
            4'd11: begin p_w = 1; p_s = 2'b10; end
            default: ;
        endcase
        if (rst) begin
            p_w = 0; p_wc = 0; ir_w = 0; m_wr = 0; m_rd = 0; r_w = 0;
        end
        return {p_w, p_wc, i_d, m_rd, m_wr, m_tr, ir_w, r_d, r_w, a_a, a_b, p_s, a_o};
    endfunction

    // Drive inputs for the current cycle, queue what the DUT must show in it.
    task automatic cyc(input int d, input logic [3:0] s, input logic mr,
                       input logic [5:0] op, input logic il);
        exp_t e;
        mr_s[d] = mr;
        op_s[d] = op;
        e.st   = s;
        e.ctrl = ctrl_of(s, mr, rst_s[d]);
        e.ill  = il;
        e.cnt  = cnt_m[d];
        e.tag  = cur_tag;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic retire(input int d);
        if (d == 1) cnt_m[d] = (cnt_m[d] + 1) & 15;
        else        cnt_m[d] = cnt_m[d] + 1;
    endtask

    task automatic do_instr(input int d, input logic [5:0] op, input int fwait,
                            input int mwait, input logic [63:0] tag);
        logic legal;
        cur_tag = tag;
        legal = (op == OP_LW) || (op == OP_SW) || (op == OP_R) || (op == OP_BEQ) ||
                ((op == OP_ADDI) && (d == 0)) || ((op == OP_J) && (d == 0));
        for (int i = 0; i < fwait; i++) cyc(d, 4'd0, 1'b0, op, 1'b0);
        cyc(d, 4'd0, 1'b1, op, 1'b0);
        cyc(d, 4'd1, ign, op, ~legal);
        if (legal) begin
            case (op)
                OP_LW: begin
                    cyc(d, 4'd2, ign, op, 1'b0);
                    for (int i = 0; i < mwait; i++) cyc(d, 4'd3, 1'b0, op, 1'b0);
                    cyc(d, 4'd3, 1'b1, op, 1'b0);
                    cyc(d, 4'd4, ign, op, 1'b0);
                end
                OP_SW: begin
                    cyc(d, 4'd2, ign, op, 1'b0);
                    for (int i = 0; i < mwait; i++) cyc(d, 4'd5, 1'b0, op, 1'b0);
                    cyc(d, 4'd5, 1'b1, op, 1'b0);
                end
                OP_R:    begin cyc(d, 4'd6, ign, op, 1'b0); cyc(d, 4'd7, ign, op, 1'b0); end
                OP_BEQ:  cyc(d, 4'd8, ign, op, 1'b0);
                OP_ADDI: begin cyc(d, 4'd9, ign, op, 1'b0); cyc(d, 4'd10, ign, op, 1'b0); end
                default: cyc(d, 4'd11, ign, op, 1'b0);
            endcase
            retire(d);
        end
        ign = ~ign;
    endtask

    // Reset in the middle of a memory wait: abandoned, counter cleared.
    task automatic reset_mid(input int d, input logic [5:0] op);
        cur_tag = "rst_mid";
        cyc(d, 4'd0, 1'b1, op, 1'b0);
        cyc(d, 4'd1, 1'b0, op, 1'b0);
        cyc(d, 4'd2, 1'b0, op, 1'b0);
        cyc(d, (op == OP_SW) ? 4'd5 : 4'd3, 1'b0, op, 1'b0);
        rst_s[d] = 1'b1;
        cnt_m[d] = 0;
        cyc(d, 4'd0, 1'b0, op, 1'b0);
        cyc(d, 4'd0, 1'b1, op, 1'b0);   // mem_ready high but strobes gated
        rst_s[d] = 1'b0;
        cur_tag = "post_rst";
        cyc(d, 4'd0, 1'b1, op, 1'b0);
    endtask

    task automatic check(input int d, input exp_t e);
        logic [3:0]  a_st;
        logic [15:0] a_ctrl;
        logic        a_ill;
        logic [31:0] a_cnt;
        a_st   = st[d];
        a_ctrl = ctrl_w[d];
        a_ill  = ill[d];
        a_cnt  = (d == 0) ? cnt0 : {28'd0, cnt1};
        nvec++;
        if (a_st !== e.st || a_ctrl !== e.ctrl || a_ill !== e.ill || a_cnt !== e.cnt) begin
            nfail++;
            $display("FAIL %s dut%0d @%0t: got st=%0d ctrl=%h ill=%b cnt=%0d, want st=%0d ctrl=%h ill=%b cnt=%0d",
                     e.tag, d, $time, a_st, a_ctrl, a_ill, a_cnt, e.st, e.ctrl, e.ill, e.cnt);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q0.size() > 0) begin e = q0.pop_front(); check(0, e); end
        if (q1.size() > 0) begin e = q1.pop_front(); check(1, e); end
    end

    initial begin
        rst_s = 2'b00; mr_s = 2'b00; op_s = '0;
        cnt_m[0] = 0; cnt_m[1] = 0; ign = 1'b0;
        #2 rst_s = 2'b11;
        @(posedge clk); #1;

        // ---------------- dut 0: default parameters ----------------
        cur_tag = "reset";
        cyc(0, 4'd0, 1'b1, OP_LW, 1'b0);
        cyc(0, 4'd0, 1'b0, OP_LW, 1'b0);
        rst_s[0] = 1'b0;
        do_instr(0, OP_LW,   0, 0, "lw");
        do_instr(0, OP_SW,   0, 3, "sw_wait");
        do_instr(0, OP_R,    0, 0, "rtype");
        do_instr(0, OP_BEQ,  0, 0, "beq");
        do_instr(0, OP_ADDI, 0, 0, "addi");
        do_instr(0, OP_J,    0, 0, "j");
        do_instr(0, OP_BAD,  0, 0, "illegal");
        do_instr(0, OP_LW,   2, 2, "lw_wait");
        reset_mid(0, OP_SW);
        rst_s[0] = 1'b1;

        // ---------------- dut 1: addi/j disabled, 4-bit count ------
        @(posedge clk); #1;
        cur_tag = "reset1";
        cyc(1, 4'd0, 1'b0, OP_R, 1'b0);
        rst_s[1] = 1'b0;
        do_instr(1, OP_J,    0, 0, "j_off");
        do_instr(1, OP_ADDI, 0, 0, "addi_off");
        for (int i = 0; i < 16; i++) do_instr(1, OP_R, 0, 0, "r_wrap");
        cur_tag = "wrapped";
        cyc(1, 4'd0, 1'b0, OP_BEQ, 1'b0);
        do_instr(1, OP_BEQ, 0, 0, "beq1");
        reset_mid(1, OP_LW);

        @(negedge clk); #1;
        nvec++;
        if (q0.size() != 0 || q1.size() != 0) begin
            nfail++;
            $display("FAIL drain: got %0d/%0d items left, want 0/0", q0.size(), q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
